hazard_control_unit: RTL and testbench

Stall/flush controller for the 5-stage pipeline and the counterpart to operand bypassing. It covers the hazards that forwarding cannot resolve: load-use dependencies, taken-branch redirects, and data-memory wait states. For each case it freezes or bubbles the right pipeline registers. It sits beside the datapath and drives the enable and clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/pipeline_pkg.sv | 43 ++++
 rtl/hazard_perf_counters.sv | 41 ++++
 rtl/hazard_control_unit.sv | 146 ++++++++++++++
 tb/tb_hazard_control_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared definitions for the 5-stage pipeline control blocks.
//   - hcu_state_e : hazard unit FSM encoding (RUN / MEM_WAIT)
//   - REG_AW      : architectural register address width
//   - X0          : hard-wired zero register address (never a real dependency)
//   - hcu_ctrl_t  : bundle of stall/flush/fault controls driven by the hazard unit
package pipeline_pkg;

  localparam int REG_AW = 5;
  typedef logic [REG_AW-1:0] reg_addr_t;
  localparam reg_addr_t X0 = '0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hcu_state_e;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
    logic mem_fault;
  } hcu_ctrl_t;

  // Decode instruction depends on a load sitting in execute.
  function automatic logic load_use_hit(
    input logic      mem_read_e,
    input logic      reg_write_e,
    input reg_addr_t waddr_e,
    input logic      use_rs1_d,
    input reg_addr_t raddr1_d,
    input logic      use_rs2_d,
    input reg_addr_t raddr2_d
  );
    return mem_read_e && reg_write_e && (waddr_e != X0) &&
           ((use_rs1_d && (raddr1_d == waddr_e)) ||
            (use_rs2_d && (raddr2_d == waddr_e)));
  endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// hazard_perf_counters: free-running performance counters for the hazard unit.
// Only instantiated when HAZARD_PERF_EN is defined.
//   clk, rst              : clock, synchronous active-high reset (clears counters)
//   stall_F               : front-end stall this cycle
//   flush_D, flush_E      : decode / execute flush this cycle
//   stall_cycles          : count of cycles with stall_F (wraps mod 2^32)
//   flush_count           : count of cycles with flush_D or flush_E (wraps mod 2^32)
module hazard_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_F,
  input  logic        flush_D,
  input  logic        flush_E,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q,  flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall_F)           stall_cycles_d = stall_cycles_q + 32'd1;
    if (flush_D || flush_E) flush_count_d = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: stall/flush controller for the 5-stage pipeline.
// Handles the hazards bypassing cannot: load-use, taken-branch redirect and
// data-memory wait states (with a bounded wait and a fault on timeout).
//   clk, rst                 : clock, synchronous active-high reset
//   Raddr1_D/Raddr2_D        : decode source registers; use_rs1_D/use_rs2_D qualify them
//   Waddr_E, RegWrite_E,
//   MemRead_E                : execute destination / writes-reg / is-load
//   branch_taken_E           : execute redirect this cycle
//   dmem_req_M, dmem_ready_M : memory-stage request and completion
//   stall_F/D/E/M            : hold PC, IF/ID, ID/EX, EX/MEM
//   flush_D/E/W              : bubble IF/ID, ID/EX, MEM/WB on next edge
//   mem_fault                : one-cycle pulse when a memory access is abandoned
//   stall_cycles/flush_count : perf counters, only with HAZARD_PERF_EN defined
// Parameter MEM_TIMEOUT (1..65535): max consecutive wait cycles per access.
// Optional feature macro: HAZARD_PERF_EN.
module hazard_control_unit
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Raddr1_D,
  input  logic [REG_AW-1:0] Raddr2_D,
  input  logic              use_rs1_D,
  input  logic              use_rs2_D,
  input  logic [REG_AW-1:0] Waddr_E,
  input  logic              RegWrite_E,
  input  logic              MemRead_E,
  input  logic              branch_taken_E,
  input  logic              dmem_req_M,
  input  logic              dmem_ready_M,
  output logic              stall_F,
  output logic              stall_D,
  output logic              stall_E,
  output logic              stall_M,
  output logic              flush_D,
  output logic              flush_E,
  output logic              flush_W,
  output logic              mem_fault
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`endif
);

  localparam int             CNT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  hcu_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic      timeout, freeze, load_use;
  hcu_ctrl_t ctrl;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ctrl       = '0;

    timeout  = (state_q == MEM_WAIT) && (wait_cnt_q == CNT_MAX);
    freeze   = dmem_req_M && !dmem_ready_M && !timeout;
    load_use = load_use_hit(MemRead_E, RegWrite_E, Waddr_E,
                            use_rs1_D, Raddr1_D, use_rs2_D, Raddr2_D);

    // Freeze holds everything up to MEM; flush_W keeps the stalled
    // instruction from writing back once per waited cycle.
    if (freeze) begin
      ctrl.stall_f = 1'b1;
      ctrl.stall_d = 1'b1;
      ctrl.stall_e = 1'b1;
      ctrl.stall_m = 1'b1;
      ctrl.flush_w = 1'b1;
    end else if (timeout) begin
      // Abandon the access: let the pipe move, drop its result.
      ctrl.mem_fault = 1'b1;
      ctrl.flush_w   = 1'b1;
    end else if (branch_taken_E) begin
      // Wrong-path instructions in D and E; load-use is moot.
      ctrl.flush_d = 1'b1;
      ctrl.flush_e = 1'b1;
    end else if (load_use) begin
      // Hold F/D one cycle, inject one bubble into E.
      ctrl.stall_f = 1'b1;
      ctrl.stall_d = 1'b1;
      ctrl.flush_e = 1'b1;
    end

    unique case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = CNT_ONE;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready_M || timeout) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    if (rst) ctrl = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign stall_F   = ctrl.stall_f;
  assign stall_D   = ctrl.stall_d;
  assign stall_E   = ctrl.stall_e;
  assign stall_M   = ctrl.stall_m;
  assign flush_D   = ctrl.flush_d;
  assign flush_E   = ctrl.flush_e;
  assign flush_W   = ctrl.flush_w;
  assign mem_fault = ctrl.mem_fault;

`ifdef HAZARD_PERF_EN
  hazard_perf_counters u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall_F      (stall_F),
    .flush_D      (flush_D),
    .flush_E      (flush_E),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;
  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Raddr1_D, Raddr2_D, Waddr_E;
  logic       use_rs1_D, use_rs2_D, RegWrite_E, MemRead_E, branch_taken_E;
  logic       dmem_req_M, dmem_ready_M;
  logic       stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W, mem_fault;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  hazard_control_unit #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .Raddr1_D(Raddr1_D), .Raddr2_D(Raddr2_D),
    .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
    .Waddr_E(Waddr_E), .RegWrite_E(RegWrite_E), .MemRead_E(MemRead_E),
    .branch_taken_E(branch_taken_E),
    .dmem_req_M(dmem_req_M), .dmem_ready_M(dmem_ready_M),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W), .mem_fault(mem_fault)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks whether an access is being waited on and for how many cycles.
  bit          m_waiting, n_waiting;
  int          m_waited, n_waited;
  int unsigned m_stalls, m_flushes, n_stalls, n_flushes;
  logic [7:0]  exp_v, dut_v;
  bit          tmo, frz, lu;

  always @(negedge clk) begin
    if (rst) begin
      exp_v = 8'h00;
      n_waiting = 0; n_waited = 0; n_stalls = 0; n_flushes = 0;
    end else begin
      tmo = m_waiting && (m_waited == TMO);
      frz = dmem_req_M && !dmem_ready_M && !tmo;
      lu  = MemRead_E && RegWrite_E && (Waddr_E != 0) &&
            ((use_rs1_D && Raddr1_D == Waddr_E) || (use_rs2_D && Raddr2_D == Waddr_E));
      // {stall F,D,E,M, flush D,E,W, fault}
      if (frz)                 exp_v = 8'b1111_0010;
      else if (tmo)            exp_v = 8'b0000_0011;
      else if (branch_taken_E) exp_v = 8'b0000_1100;
      else if (lu)             exp_v = 8'b1100_0100;
      else                     exp_v = 8'b0000_0000;
      n_waiting = m_waiting; n_waited = m_waited;
      if (!m_waiting) begin
        if (frz) begin n_waiting = 1; n_waited = 1; end
      end else if (dmem_ready_M || tmo) begin
        n_waiting = 0; n_waited = 0;
      end else begin
        n_waited = m_waited + 1;
      end
      n_stalls  = m_stalls + (exp_v[7] ? 1 : 0);
      n_flushes = m_flushes + ((exp_v[3] | exp_v[2]) ? 1 : 0);
    end
    dut_v = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W, mem_fault};
    chk("ctrl_vs_model", {24'h0, dut_v}, {24'h0, exp_v});
`ifdef HAZARD_PERF_EN
    chk("stall_cycles_vs_model", stall_cycles, m_stalls);
    chk("flush_count_vs_model", flush_count, m_flushes);
`endif
  end

  always @(posedge clk) begin
    m_waiting <= n_waiting;
    m_waited  <= n_waited;
    m_stalls  <= n_stalls;
    m_flushes <= n_flushes;
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    Raddr1_D = '0; Raddr2_D = '0; Waddr_E = '0;
    use_rs1_D = 0; use_rs2_D = 0; RegWrite_E = 0; MemRead_E = 0;
    branch_taken_E = 0; dmem_req_M = 0; dmem_ready_M = 0;
  endtask

  // inputs are set before calling; sample at negedge, return at posedge+1
  task automatic sample();
    @(negedge clk);
  endtask
  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic set_lu(input logic [4:0] w);
    MemRead_E = 1; RegWrite_E = 1; Waddr_E = w; Raddr2_D = 5'd5; use_rs2_D = 1;
  endtask

  initial begin
    rst = 1; idle();
    sample(); chk("reset_outputs_zero", {24'h0, stall_F, stall_D, stall_E, stall_M,
                  flush_D, flush_E, flush_W, mem_fault}, 32'h0);
    next();
    // load-use asserted during reset must still be silent
    set_lu(5'd5); dmem_req_M = 1;
    sample(); chk("reset_masks_lu", {31'h0, stall_F}, 32'h0);
    next(); rst = 0; idle();
    sample(); chk("idle_no_stall", {31'h0, stall_F}, 32'h0);
    next();

    // load-use: one bubble, then the load has advanced
    set_lu(5'd5);
    sample();
    chk("lu_stall_F", {31'h0, stall_F}, 32'h1);
    chk("lu_stall_D", {31'h0, stall_D}, 32'h1);
    chk("lu_flush_E", {31'h0, flush_E}, 32'h1);
    chk("lu_no_stall_E", {31'h0, stall_E}, 32'h0);
    next(); idle();
    sample(); chk("lu_one_cycle", {31'h0, stall_F}, 32'h0);
    next();
    set_lu(5'd0); Raddr2_D = 5'd0;
    sample(); chk("lu_x0_no_stall", {31'h0, stall_F}, 32'h0);
    next();

    // redirect coincident with load-use
    set_lu(5'd5); branch_taken_E = 1;
    sample();
    chk("br_flush_D", {31'h0, flush_D}, 32'h1);
    chk("br_flush_E", {31'h0, flush_E}, 32'h1);
    chk("br_no_stall_F", {31'h0, stall_F}, 32'h0);
    next(); idle();

    // same-cycle ready: no freeze
    dmem_req_M = 1; dmem_ready_M = 1;
    sample(); chk("req_ready_same_cycle", {31'h0, stall_M}, 32'h0);
    next();

    // memory wait: 3 waited cycles, then ready
    dmem_ready_M = 0;
    for (int i = 0; i < 3; i++) begin
      sample(); chk("wait_stall_M", {30'h0, stall_M, flush_W}, 32'h3);
      next();
    end
    dmem_ready_M = 1;
    sample(); chk("ready_release", {29'h0, stall_F, stall_M, flush_W}, 32'h0);
    next();

    // back-to-back request, never ready: 4 stall cycles then fault
    dmem_ready_M = 0;
    for (int i = 0; i < TMO; i++) begin
      sample(); chk("b2b_wait_stall", {30'h0, stall_F, mem_fault}, 32'h2);
      next();
    end
    sample();
    chk("timeout_fault", {31'h0, mem_fault}, 32'h1);
    chk("timeout_flush_W", {31'h0, flush_W}, 32'h1);
    chk("timeout_no_stall", {28'h0, stall_F, stall_D, stall_E, stall_M}, 32'h0);
    next(); idle();
    sample(); chk("fault_one_pulse", {31'h0, mem_fault}, 32'h0);
    next();

    // reset on the 2nd wait cycle
    dmem_req_M = 1;
    sample(); chk("pre_rst_wait", {31'h0, stall_M}, 32'h1);
    next(); rst = 1;
    sample(); chk("rst_mid_wait", {24'h0, stall_F, stall_D, stall_E, stall_M,
                  flush_D, flush_E, flush_W, mem_fault}, 32'h0);
    next(); rst = 0;
    for (int i = 0; i < TMO; i++) begin
      sample(); chk("post_rst_wait", {31'h0, stall_M}, 32'h1);
      next();
    end
    sample(); chk("post_rst_timeout", {31'h0, mem_fault}, 32'h1);
    next(); idle();

    // perf: 3 load-use stalls + 2 redirects from a clean reset
    rst = 1; sample(); next(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      set_lu(5'd5); sample(); next(); idle(); sample(); next();
    end
    for (int i = 0; i < 2; i++) begin
      branch_taken_E = 1; sample(); next(); idle();
    end
    sample();
`ifdef HAZARD_PERF_EN
    chk("perf_stall_cycles", stall_cycles, 32'd3);
    chk("perf_flush_count", flush_count, 32'd5);
`endif
    next();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      Raddr1_D       = 5'($urandom_range(0, 3));
      Raddr2_D       = 5'($urandom_range(0, 3));
      Waddr_E        = 5'($urandom_range(0, 3));
      use_rs1_D      = 1'($urandom_range(0, 1));
      use_rs2_D      = 1'($urandom_range(0, 1));
      RegWrite_E     = ($urandom_range(0, 3) != 0);
      MemRead_E      = ($urandom_range(0, 2) == 0);
      branch_taken_E = ($urandom_range(0, 5) == 0);
      dmem_req_M     = ($urandom_range(0, 9) < 6);
      dmem_ready_M   = ($urandom_range(0, 9) < 3);
      sample(); next();
    end
    rst = 0; idle(); sample(); next();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
